aeolus_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the Aeolus 4-bit datapath. Owns the PC, reads
//  a registered-output program ROM, latches the opcode into an IR and issues exactly one one-cycle

---
 rtl/aeolus_pkg.sv | 34 +++
 rtl/aeolus_opdecode.sv | 19 +
 rtl/aeolus_sequencer.sv | 101 ++++++++++
 tb/tb_aeolus_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aeolus_pkg.sv
// Shared constants for the Aeolus sequencer: opcode map, FSM state encoding
// and the width of the one-hot datapath strobe bus.
package aeolus_pkg;

    localparam int STROBE_W = 16;

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDO  = 4'd2;
    localparam logic [3:0] OP_LDSA = 4'd3;
    localparam logic [3:0] OP_LDSB = 4'd4;
    localparam logic [3:0] OP_LSH  = 4'd5;
    localparam logic [3:0] OP_RSH  = 4'd6;
    localparam logic [3:0] OP_CLR  = 4'd7;
    localparam logic [3:0] OP_SNZA = 4'd8;
    localparam logic [3:0] OP_SNZS = 4'd9;
    localparam logic [3:0] OP_ADD  = 4'd10;
    localparam logic [3:0] OP_SUB  = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12;
    localparam logic [3:0] OP_OR   = 4'd13;
    localparam logic [3:0] OP_XOR  = 4'd14;
    localparam logic [3:0] OP_INV  = 4'd15;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    // SNZA/SNZS only fire their strobe when the shifter flag is set
    function automatic logic is_cond_op(input logic [3:0] op);
        return (op == OP_SNZA) || (op == OP_SNZS);
    endfunction

endpackage

// File: rtl/aeolus_opdecode.sv
// Combinational opcode decoder: 4-bit opcode -> one-hot datapath strobe,
// gated by enable and, for the conditional opcodes, by the shifter flag.
module aeolus_opdecode
    import aeolus_pkg::*;
(
    input  logic [3:0]          opcode,
    input  logic                sf,
    input  logic                enable,
    output logic [STROBE_W-1:0] strobe
);

    generate
        for (genvar gi = 0; gi < STROBE_W; gi++) begin : g_bit
            localparam logic [3:0] OPV = 4'(gi);
            assign strobe[gi] = enable & (opcode == OPV) & (sf | ~is_cond_op(OPV));
        end
    endgenerate

endmodule

// File: rtl/aeolus_sequencer.sv
// Fetch/load/execute controller for the Aeolus 4-bit datapath: owns PC, IR,
// retired-instruction counter and the sticky end-of-program flag.
module aeolus_sequencer
    import aeolus_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int PROG_LEN    = 256,
    parameter int HALT_ON_END = 1,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [3:0]          rom_data,
    input  logic                sf,
    output logic [STROBE_W-1:0] strobe,
    output logic                busy,
    output logic                instr_done,
    output logic                halted,
    output logic [CNT_W-1:0]    icount
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);
    localparam bit                HALT_EN   = (HALT_ON_END != 0);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [3:0]        ir_reg;
    logic [CNT_W-1:0]  icount_reg;
    logic              halted_reg;
    logic              busy_reg;
    logic              instr_done_reg;
    logic              at_end;
    logic              halting;

    assign at_end  = (pc_reg == LAST_ADDR);
    assign halting = HALT_EN & at_end;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if ((run | step) & ~halted_reg) state_next = S_FETCH;
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_EXEC;
            S_EXEC:  state_next = (run & ~halting) ? S_FETCH : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The ROM's registered output lands during LOAD, so the opcode is
    // captured on the LOAD->EXEC edge. PC wraps naturally when the program
    // fills the whole address space.
    always_comb begin
        pc_next = pc_reg + ADDR_W'(1);
        if (at_end) begin
            pc_next = HALT_EN ? pc_reg : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            pc_reg         <= '0;
            ir_reg         <= '0;
            icount_reg     <= '0;
            halted_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            instr_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            busy_reg       <= (state_next != S_IDLE);
            instr_done_reg <= (state_next == S_EXEC);
            if (state_reg == S_LOAD) begin
                ir_reg <= rom_data;
            end
            if (state_reg == S_EXEC) begin
                icount_reg <= icount_reg + CNT_W'(1);
                pc_reg     <= pc_next;
                if (halting) begin
                    halted_reg <= 1'b1;
                end
            end
        end
    end

    aeolus_opdecode u_opdecode (
        .opcode (ir_reg),
        .sf     (sf),
        .enable (state_reg == S_EXEC),
        .strobe (strobe)
    );

    assign rom_addr   = pc_reg;
    assign busy       = busy_reg;
    assign instr_done = instr_done_reg;
    assign halted     = halted_reg;
    assign icount     = icount_reg;

endmodule

// File: tb/tb_aeolus_sequencer.sv
// Scoreboard bench for aeolus_sequencer: one halting instance and one
// wrapping instance, each with a registered 4-word program ROM model.
module tb_aeolus_sequencer;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       run;
    logic             step;
    logic             step_b;
    logic             sf;
    logic [1:0][7:0]  rom_addr;
    logic [1:0][3:0]  rom_q;
    logic [1:0][15:0] strobe;
    logic [1:0][15:0] icount;
    logic [1:0]       busy;
    logic [1:0]       instr_done;
    logic [1:0]       halted;
    logic [3:0]       rom [4];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_fail = 0;

    typedef struct {
        int          dut;
        logic [15:0] strobe;
        logic [7:0]  pc;
        logic [15:0] ic;
        int          gap;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rom_q[0] <= rom[rom_addr[0][1:0]];
        rom_q[1] <= rom[rom_addr[1][1:0]];
    end

    aeolus_sequencer #(.ADDR_W(8), .PROG_LEN(4), .HALT_ON_END(1), .CNT_W(16)) dut_halt (
        .clk(clk), .reset(reset), .run(run[0]), .step(step),
        .rom_addr(rom_addr[0]), .rom_data(rom_q[0]), .sf(sf),
        .strobe(strobe[0]), .busy(busy[0]), .instr_done(instr_done[0]),
        .halted(halted[0]), .icount(icount[0])
    );

    aeolus_sequencer #(.ADDR_W(8), .PROG_LEN(4), .HALT_ON_END(0), .CNT_W(16)) dut_wrap (
        .clk(clk), .reset(reset), .run(run[1]), .step(step_b),
        .rom_addr(rom_addr[1]), .rom_data(rom_q[1]), .sf(sf),
        .strobe(strobe[1]), .busy(busy[1]), .instr_done(instr_done[1]),
        .halted(halted[1]), .icount(icount[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_retire(input int d, input logic [15:0] s, input logic [7:0] pc,
                                 input logic [15:0] ic, input int gap);
        exp_t e;
        e.dut = d; e.strobe = s; e.pc = pc; e.ic = ic; e.gap = gap;
        sbq.push_back(e);
    endtask

    // Monitor: every instr_done pulse must match the oldest pending expectation
    task automatic mon(input int d);
        int   last = -1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_done[d]) begin
                $display("[%0t] dut%0d retire pc=%0d strobe=0x%04h icount=%0d",
                         $time, d, rom_addr[d], strobe[d], icount[d]);
                if (sbq.size() == 0 || sbq[0].dut != d) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_retire dut%0d: got retire pc=%0d, required none",
                             d, rom_addr[d]);
                end else begin
                    e = sbq.pop_front();
                    chk("retire_strobe", 32'(strobe[d]), 32'(e.strobe));
                    chk("retire_pc", 32'(rom_addr[d]), 32'(e.pc));
                    chk("retire_icount", 32'(icount[d]), 32'(e.ic));
                    if (e.gap > 0) chk("retire_gap", cyc - last, e.gap);
                end
                last = cyc;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_idle(input int d);
        int k = 0;
        while (busy[d] && k < 30) begin tick(); k++; end
        chk("wait_idle", 32'(busy[d]), 32'd0);
    endtask

    task automatic wait_halt();
        int k = 0;
        while (!halted[0] && k < 60) begin tick(); k++; end
        chk("wait_halt", 32'(halted[0]), 32'd1);
    endtask

    task automatic wait_icount(input int d, input logic [15:0] v);
        int k = 0;
        while (icount[d] != v && k < 60) begin tick(); k++; end
        chk("wait_icount", 32'(icount[d]), 32'(v));
    endtask

    task automatic load_base_prog();
        rom[0] = 4'd0; rom[1] = 4'd1; rom[2] = 4'd10; rom[3] = 4'd2;
    endtask

    initial begin
        reset = 1'b0; run = 2'b00; step = 1'b0; step_b = 1'b0; sf = 1'b0;
        load_base_prog();
        fork
            mon(0);
            mon(1);
        join_none

        // Reset held with run high
        run[0] = 1'b1;
        tick();
        tick();
        chk("rst_pc", 32'(rom_addr[0]), 32'd0);
        chk("rst_strobe", 32'(strobe[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_icount", 32'(icount[0]), 32'd0);
        chk("rst_halted", 32'(halted[0]), 32'd0);
        chk("rst_done", 32'(instr_done[0]), 32'd0);

        // Free run to end of program, then halt
        expect_retire(0, 16'h0001, 8'd0, 16'd0, 0);
        expect_retire(0, 16'h0002, 8'd1, 16'd1, 3);
        expect_retire(0, 16'h0400, 8'd2, 16'd2, 3);
        expect_retire(0, 16'h0004, 8'd3, 16'd3, 3);
        reset = 1'b1;
        wait_halt();
        tick();
        chk("run_icount", 32'(icount[0]), 32'd4);
        chk("run_pc", 32'(rom_addr[0]), 32'd3);
        chk("run_busy", 32'(busy[0]), 32'd0);
        repeat (4) tick();
        chk("halt_ignores_run", 32'(busy[0]), 32'd0);
        run[0] = 1'b0;
        step = 1'b1; tick(); step = 1'b0; tick();
        chk("halt_ignores_step", 32'(busy[0]), 32'd0);
        chk("halt_sticky", 32'(halted[0]), 32'd1);

        // Conditional SNZA with sf low then SNZS with sf high
        do_reset();
        chk("rst_clears_halted", 32'(halted[0]), 32'd0);
        rom[0] = 4'd8; rom[1] = 4'd9; sf = 1'b0;
        expect_retire(0, 16'h0000, 8'd0, 16'd0, 0);
        step = 1'b1; tick(); step = 1'b0;
        wait_idle(0);
        chk("cond0_icount", 32'(icount[0]), 32'd1);
        chk("cond0_pc", 32'(rom_addr[0]), 32'd1);
        sf = 1'b1;
        expect_retire(0, 16'h0200, 8'd1, 16'd1, 0);
        step = 1'b1; tick(); step = 1'b0;
        wait_idle(0);
        chk("cond1_icount", 32'(icount[0]), 32'd2);
        sf = 1'b0;

        // Single step with a second pulse arriving while busy
        do_reset();
        load_base_prog();
        expect_retire(0, 16'h0001, 8'd0, 16'd0, 0);
        step = 1'b1; tick(); step = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        wait_idle(0);
        chk("step_pc", 32'(rom_addr[0]), 32'd1);
        chk("step_icount", 32'(icount[0]), 32'd1);
        repeat (3) tick();
        chk("step_dropped_icount", 32'(icount[0]), 32'd1);
        chk("step_dropped_busy", 32'(busy[0]), 32'd0);

        // Reset during LOAD, then restart from address 0
        do_reset();
        run[0] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_strobe", 32'(strobe[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_pc", 32'(rom_addr[0]), 32'd0);
        chk("midrst_done", 32'(instr_done[0]), 32'd0);
        expect_retire(0, 16'h0001, 8'd0, 16'd0, 0);
        expect_retire(0, 16'h0002, 8'd1, 16'd1, 3);
        expect_retire(0, 16'h0400, 8'd2, 16'd2, 3);
        expect_retire(0, 16'h0004, 8'd3, 16'd3, 3);
        reset = 1'b1;
        wait_halt();
        tick();
        chk("midrst_icount", 32'(icount[0]), 32'd4);
        run[0] = 1'b0;

        // Wrapping instance: PC returns to 0 after the last word
        do_reset();
        expect_retire(1, 16'h0001, 8'd0, 16'd0, 0);
        expect_retire(1, 16'h0002, 8'd1, 16'd1, 3);
        expect_retire(1, 16'h0400, 8'd2, 16'd2, 3);
        expect_retire(1, 16'h0004, 8'd3, 16'd3, 3);
        expect_retire(1, 16'h0001, 8'd0, 16'd4, 3);
        expect_retire(1, 16'h0002, 8'd1, 16'd5, 3);
        run[1] = 1'b1;
        wait_icount(1, 16'd5);
        chk("wrap_pc", 32'(rom_addr[1]), 32'd1);
        run[1] = 1'b0;
        wait_idle(1);
        chk("wrap_halted", 32'(halted[1]), 32'd0);
        chk("wrap_icount", 32'(icount[1]), 32'd6);
        chk("wrap_pc_final", 32'(rom_addr[1]), 32'd2);

        repeat (2) tick();
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
